baud_ctrl: RTL and testbench

Controller for the UART baud clock divider. Holds the divider's `count` setting and accepts software reconfiguration through a valid/ready handshake. Optionally measures an incoming 0x55 sync character on `rx` to derive `count` automatically (autobaud). Whenever `count` changes, it resets the divider for one cycle so the divider counter never runs past a smaller new terminal value. Sits between the AXI register block and the baud divider in the UART SoC peripheral.

---
 rtl/baud_pkg.sv | 20 ++
 rtl/baud_measure.sv | 82 ++++++++
 rtl/baud_ctrl.sv | 169 ++++++++++++++++
 tb/tb_baud_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/baud_pkg.sv
// Shared types and constants for the UART baud clock controller.
package baud_pkg;

  localparam int SYNC_FALLS = 5;
  localparam int SYNC_BITS  = 8;
  localparam int COUNT_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_HIGH = 3'd1,
    ST_WAIT_FALL = 3'd2,
    ST_MEASURE   = 3'd3,
    ST_APPLY     = 3'd4
  } state_e;

  function automatic logic is_busy(state_e s);
    return (s == ST_WAIT_HIGH) || (s == ST_WAIT_FALL) || (s == ST_MEASURE);
  endfunction

endpackage

// File: rtl/baud_measure.sv
// Autobaud measurement datapath: rx synchronizer, falling-edge detect, span,
// falls and timeout counters. Used only when BAUD_CTRL_AUTOBAUD_EN is defined.
module baud_measure
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE = 16,
  parameter int SPAN_W     = 24
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               rx,
  input  logic               start,
  input  state_e             state,
  output logic               rx_high,
  output logic               fall,
  output logic               done,
  output logic               err,
  output logic [COUNT_W-1:0] result
);

  localparam int L  = $clog2(OVERSAMPLE);
  localparam int SH = L + $clog2(SYNC_BITS) + 1;
  localparam int W  = SPAN_W + COUNT_W + 2;

  logic [2:0]        sync_q, sync_d;
  logic [SPAN_W-1:0] span_q, span_d;
  logic [SPAN_W-1:0] tmo_q, tmo_d;
  logic [2:0]        falls_q, falls_d;
  logic [W-1:0]      res_wide;
  logic              busy, timeout, fifth, res_ok;

  // sync_q[1] is the synchronized line, sync_q[2] its previous value
  assign sync_d  = {sync_q[1:0], rx};
  assign rx_high = sync_q[1];
  assign fall    = sync_q[2] & ~sync_q[1];

  assign busy    = is_busy(state);
  assign timeout = busy && (tmo_q == '1);
  assign fifth   = (state == ST_MEASURE) && fall && (falls_q == 3'(SYNC_FALLS - 1));

  // span_q + 1 includes the current cycle, so the span is exactly 8 bit times
  assign res_wide = (W'(span_q) + W'(1) + (W'(1) << (SH - 1))) >> SH;
  assign res_ok   = (res_wide != '0) && ((res_wide >> COUNT_W) == '0);
  assign result   = res_wide[COUNT_W-1:0];
  assign done     = fifth && res_ok && !timeout;
  assign err      = timeout || (fifth && !res_ok);

  always_comb begin
    tmo_d   = tmo_q;
    span_d  = span_q;
    falls_d = falls_q;
    if (start) begin
      tmo_d   = '0;
      span_d  = '0;
      falls_d = '0;
    end else begin
      if (busy && !timeout) tmo_d = tmo_q + 1'b1;
      if ((state == ST_WAIT_FALL) && fall) begin
        span_d  = '0;
        falls_d = 3'd1;
      end else if (state == ST_MEASURE) begin
        span_d = span_q + 1'b1;
        if (fall) falls_d = falls_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= 3'b111;
      span_q  <= '0;
      tmo_q   <= '0;
      falls_q <= '0;
    end else begin
      sync_q  <= sync_d;
      span_q  <= span_d;
      tmo_q   <= tmo_d;
      falls_q <= falls_d;
    end
  end

endmodule

// File: rtl/baud_ctrl.sv
// Baud divider controller: holds count, takes software writes, pulses the divider
// reset on every change. Autobaud path present when BAUD_CTRL_AUTOBAUD_EN is defined.
//
// state      | meaning
// IDLE       | ready for a cfg write or ab_start
// WAIT_HIGH  | autobaud: waiting for rx idle high
// WAIT_FALL  | autobaud: waiting for the start-bit falling edge
// MEASURE    | autobaud: timing the span up to the 5th falling edge
// APPLY      | one cycle: load count, hold divider in reset
module baud_ctrl
  import baud_pkg::*;
#(
  parameter int OVERSAMPLE    = 16,
  parameter int DEFAULT_COUNT = 27,
  parameter int SPAN_W        = 24
) (
  input  logic               clk_in,
  input  logic               reset_n,
  input  logic               cfg_valid,
  input  logic [COUNT_W-1:0] cfg_count,
  output logic               cfg_ready,
  input  logic               ab_start,
  input  logic               rx,
  output logic               ab_busy,
  output logic               ab_done,
  output logic               ab_err,
  output logic [COUNT_W-1:0] count,
  output logic               div_reset_n
);

  state_e             state_q, state_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [COUNT_W-1:0] latch_q, latch_d;
  logic               cfg_ready_q, cfg_ready_d;
  logic               div_reset_n_q, div_reset_n_d;
  logic               ab_busy_q, ab_busy_d;
  logic               ab_done_q, ab_done_d;
  logic               ab_err_q, ab_err_d;

`ifdef BAUD_CTRL_AUTOBAUD_EN
  logic               from_ab_q, from_ab_d;
  logic               meas_start, meas_high, meas_fall, meas_done, meas_err;
  logic [COUNT_W-1:0] meas_result;

  baud_measure #(
    .OVERSAMPLE (OVERSAMPLE),
    .SPAN_W     (SPAN_W)
  ) u_measure (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .rx      (rx),
    .start   (meas_start),
    .state   (state_q),
    .rx_high (meas_high),
    .fall    (meas_fall),
    .done    (meas_done),
    .err     (meas_err),
    .result  (meas_result)
  );
`else
  logic [SPAN_W+OVERSAMPLE-1:0] ab_unused;
  assign ab_unused = {{(SPAN_W+OVERSAMPLE-1){1'b0}}, ab_start ^ rx};
`endif

  always_comb begin
    state_d   = state_q;
    latch_d   = latch_q;
    count_d   = count_q;
    ab_done_d = 1'b0;
    ab_err_d  = 1'b0;
`ifdef BAUD_CTRL_AUTOBAUD_EN
    from_ab_d  = from_ab_q;
    meas_start = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (cfg_valid && cfg_ready_q) begin
          latch_d = (cfg_count == '0) ? COUNT_W'(1) : cfg_count;
          state_d = ST_APPLY;
        end
`ifdef BAUD_CTRL_AUTOBAUD_EN
        // a pending cfg write always wins over ab_start
        else if (ab_start && !cfg_valid) begin
          meas_start = 1'b1;
          state_d    = ST_WAIT_HIGH;
        end
        from_ab_d = 1'b0;
`endif
      end
`ifdef BAUD_CTRL_AUTOBAUD_EN
      ST_WAIT_HIGH: begin
        if (meas_err) begin
          ab_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (meas_high) begin
          state_d = ST_WAIT_FALL;
        end
      end
      ST_WAIT_FALL: begin
        if (meas_err) begin
          ab_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (meas_fall) begin
          state_d = ST_MEASURE;
        end
      end
      ST_MEASURE: begin
        if (meas_err) begin
          ab_err_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (meas_done) begin
          latch_d   = meas_result;
          from_ab_d = 1'b1;
          state_d   = ST_APPLY;
        end
      end
`endif
      ST_APPLY: begin
        count_d = latch_q;
        state_d = ST_IDLE;
`ifdef BAUD_CTRL_AUTOBAUD_EN
        ab_done_d = from_ab_q;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // ready only after a full cycle back in IDLE, so APPLY is never overlapped
    cfg_ready_d   = (state_q == ST_IDLE) && (state_d == ST_IDLE);
    div_reset_n_d = (state_q != ST_APPLY);
    ab_busy_d     = is_busy(state_d);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= ST_IDLE;
      count_q       <= COUNT_W'(DEFAULT_COUNT);
      latch_q       <= COUNT_W'(DEFAULT_COUNT);
      cfg_ready_q   <= 1'b0;
      div_reset_n_q <= 1'b0;
      ab_busy_q     <= 1'b0;
      ab_done_q     <= 1'b0;
      ab_err_q      <= 1'b0;
`ifdef BAUD_CTRL_AUTOBAUD_EN
      from_ab_q     <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      count_q       <= count_d;
      latch_q       <= latch_d;
      cfg_ready_q   <= cfg_ready_d;
      div_reset_n_q <= div_reset_n_d;
      ab_busy_q     <= ab_busy_d;
      ab_done_q     <= ab_done_d;
      ab_err_q      <= ab_err_d;
`ifdef BAUD_CTRL_AUTOBAUD_EN
      from_ab_q     <= from_ab_d;
`endif
    end
  end

  assign count       = count_q;
  assign cfg_ready   = cfg_ready_q;
  assign div_reset_n = div_reset_n_q;
  assign ab_busy     = ab_busy_q;
  assign ab_done     = ab_done_q;
  assign ab_err      = ab_err_q;

endmodule

// File: tb/tb_baud_ctrl.sv
// Directed bench for baud_ctrl; autobaud cases run when BAUD_CTRL_AUTOBAUD_EN is defined.
`timescale 1ns/1ps
module tb_baud_ctrl;

  logic        clk_in = 1'b0;
  logic        reset_n;
  logic        cfg_valid;
  logic [15:0] cfg_count;
  logic        ab_start, ab_start_s, rx;

  logic        cfg_ready, ab_busy, ab_done, ab_err, div_reset_n;
  logic [15:0] count;
  logic        cfg_ready_s, ab_busy_s, ab_done_s, ab_err_s, div_reset_n_s;
  logic [15:0] count_s;

  int          checks = 0;
  int          errors = 0;
  int          done_n = 0, err_n = 0, dlow_n = 0, done_s_n = 0, err_s_n = 0;
  logic [15:0] done_count = '0;

  always #5 clk_in = ~clk_in;

  baud_ctrl u_dut (
    .clk_in (clk_in), .reset_n (reset_n),
    .cfg_valid (cfg_valid), .cfg_count (cfg_count), .cfg_ready (cfg_ready),
    .ab_start (ab_start), .rx (rx), .ab_busy (ab_busy), .ab_done (ab_done),
    .ab_err (ab_err), .count (count), .div_reset_n (div_reset_n)
  );

  // short timeout instance for the error cases
  baud_ctrl #(.SPAN_W(12)) u_small (
    .clk_in (clk_in), .reset_n (reset_n),
    .cfg_valid (cfg_valid), .cfg_count (cfg_count), .cfg_ready (cfg_ready_s),
    .ab_start (ab_start_s), .rx (rx), .ab_busy (ab_busy_s), .ab_done (ab_done_s),
    .ab_err (ab_err_s), .count (count_s), .div_reset_n (div_reset_n_s)
  );

  always @(negedge clk_in) begin
    if (reset_n) begin
      if (ab_done) begin
        done_n     <= done_n + 1;
        done_count <= count;
      end
      if (ab_err)       err_n    <= err_n + 1;
      if (!div_reset_n) dlow_n   <= dlow_n + 1;
      if (ab_done_s)    done_s_n <= done_s_n + 1;
      if (ab_err_s)     err_s_n  <= err_s_n + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk_in);
    #1;
  endtask

  // returns just after the handshake edge with cfg_valid dropped
  task automatic cfg_write(input logic [15:0] v);
    int n;
    n = 0;
    cfg_count = v;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 200) begin
      tick(1);
      n++;
    end
    check_eq("cfg_ready_wait", 32'(n < 200), 1);
    tick(1);
    cfg_valid = 1'b0;
  endtask

  // start bit, 0x55 LSB first, stop bit; each bit held t cycles
  task automatic send_frame(input int t, input int nbits);
    logic [9:0] pat;
    pat = {1'b1, 8'h55, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      rx = pat[i];
      tick(t);
    end
  endtask

  task automatic run_ab(input string tag, input int t, input logic [15:0] exp);
    int d, e;
    d = done_n;
    e = err_n;
    ab_start = 1'b1;
    tick(1);
    ab_start = 1'b0;
    check_eq({tag, "_busy_on"}, ab_busy, 1);
    tick(5);
    send_frame(t, 9);
    rx = 1'b1;
    tick(10);
    check_eq({tag, "_done_pulses"}, done_n - d, 1);
    check_eq({tag, "_err_pulses"}, err_n - e, 0);
    check_eq({tag, "_done_count"}, done_count, exp);
    check_eq({tag, "_count"}, count, exp);
    check_eq({tag, "_busy_off"}, ab_busy, 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog got no finish exp finish");
    $fatal(1);
  end

  initial begin
    int d0, d, e, n;
    reset_n    = 1'b0;
    cfg_valid  = 1'b0;
    cfg_count  = '0;
    ab_start   = 1'b0;
    ab_start_s = 1'b0;
    rx         = 1'b1;
    tick(2);
    check_eq("rst_count", count, 27);
    check_eq("rst_div_reset_n", div_reset_n, 0);
    check_eq("rst_cfg_ready", cfg_ready, 0);
    check_eq("rst_ab_busy", ab_busy, 0);
    reset_n = 1'b1;
    check_eq("rel_div_still_low", div_reset_n, 0);
    check_eq("rel_ready_still_low", cfg_ready, 0);
    tick(1);
    check_eq("rel_div_high", div_reset_n, 1);
    check_eq("rel_ready_high", cfg_ready, 1);

    // write 54: ready low two cycles, divider reset for exactly one
    d0 = dlow_n;
    cfg_write(16'd54);
    check_eq("w54_ready_n1", cfg_ready, 0);
    check_eq("w54_count_n1", count, 27);
    check_eq("w54_div_n1", div_reset_n, 1);
    tick(1);
    check_eq("w54_count_apply", count, 54);
    check_eq("w54_div_apply", div_reset_n, 0);
    check_eq("w54_ready_apply", cfg_ready, 0);
    tick(1);
    check_eq("w54_div_after", div_reset_n, 1);
    check_eq("w54_ready_after", cfg_ready, 1);
    check_eq("w54_count_after", count, 54);
    check_eq("w54_div_low_cycles", dlow_n - d0, 1);

    cfg_write(16'd0);
    tick(2);
    check_eq("w0_clamp", count, 1);

    // cfg_valid and ab_start together: cfg wins
    ab_start = 1'b1;
    cfg_write(16'd77);
    ab_start = 1'b0;
    tick(1);
    check_eq("coll_busy_a", ab_busy, 0);
    tick(2);
    check_eq("coll_busy_b", ab_busy, 0);
    check_eq("coll_count", count, 77);

`ifdef BAUD_CTRL_AUTOBAUD_EN
    // (6944+128)>>8 = 27, (17360+128)>>8 = 68
    run_ab("ab868", 868, 16'd27);
    run_ab("ab2170", 2170, 16'd68);

    // write held during autobaud is taken only after ab_done
    d = done_n;
    ab_start = 1'b1;
    tick(1);
    ab_start  = 1'b0;
    cfg_count = 16'd100;
    cfg_valid = 1'b1;
    tick(1);
    check_eq("stall_ready", cfg_ready, 0);
    fork
      begin
        tick(4);
        send_frame(868, 9);
        rx = 1'b1;
      end
      begin
        int m;
        m = 0;
        while (!cfg_ready && m < 20000) begin
          tick(1);
          m++;
        end
        check_eq("stall_wait", 32'(m < 20000), 1);
        check_eq("stall_after_done", done_n - d, 1);
        tick(1);
        cfg_valid = 1'b0;
      end
    join
    tick(3);
    check_eq("stall_done_count", done_count, 27);
    check_eq("stall_count", count, 100);

    // reset after the 3rd falling edge
    d = done_n;
    e = err_n;
    ab_start = 1'b1;
    tick(1);
    ab_start = 1'b0;
    tick(4);
    send_frame(868, 5);
    check_eq("mid_busy", ab_busy, 1);
    reset_n = 1'b0;
    tick(2);
    check_eq("mid_rst_count", count, 27);
    check_eq("mid_rst_busy", ab_busy, 0);
    reset_n = 1'b1;
    rx = 1'b1;
    tick(5);
    check_eq("mid_count", count, 27);
    check_eq("mid_busy_off", ab_busy, 0);
    check_eq("mid_ready", cfg_ready, 1);
    check_eq("mid_no_done", done_n - d, 0);
    check_eq("mid_no_err", err_n - e, 0);

    // rx stuck low: timeout after the 12-bit counter saturates
    e = err_s_n;
    rx = 1'b0;
    tick(4);
    ab_start_s = 1'b1;
    tick(1);
    ab_start_s = 1'b0;
    n = 0;
    while (!ab_err_s && n < 5000) begin
      tick(1);
      n++;
    end
    check_eq("tmo_cycles", n, 4096);
    check_eq("tmo_count", count_s, 27);
    tick(1);
    check_eq("tmo_pulse_width", ab_err_s, 0);
    check_eq("tmo_busy_off", ab_busy_s, 0);
    check_eq("tmo_err_pulses", err_s_n - e, 1);
    rx = 1'b1;
    tick(4);

    // 4 cycles/bit: (32+128)>>8 = 0 rejected
    e = err_s_n;
    ab_start_s = 1'b1;
    tick(1);
    ab_start_s = 1'b0;
    tick(4);
    send_frame(4, 9);
    rx = 1'b1;
    tick(10);
    check_eq("fast_err_pulses", err_s_n - e, 1);
    check_eq("fast_no_done", done_s_n, 0);
    check_eq("fast_count", count_s, 27);
`else
    ab_start = 1'b1;
    rx = 1'b0;
    tick(1);
    ab_start = 1'b0;
    tick(3);
    check_eq("noab_busy", ab_busy, 0);
    check_eq("noab_ready", cfg_ready, 1);
    check_eq("noab_div", div_reset_n, 1);
    check_eq("noab_count", count, 77);
    rx = 1'b1;
    tick(2);
    check_eq("noab_done_pulses", done_n, 0);
    check_eq("noab_err_pulses", err_n, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
